// File: rtl/creator_pkg.sv
// creator_pkg: shared ForthSuper dictionary definitions.
//   creator_sts : state encoding of the header writer (creator).
//   NULL_LFA    : link value that marks the end of the dictionary chain.
package creator_pkg;

  typedef enum logic [2:0] {IDL, LK0, LK1, RD, WR, DON} creator_sts;

  localparam logic [16:0] NULL_LFA = 17'h0ffff;

endpackage

// File: rtl/mb_blk_if.sv
// mb_blk_if: generic memory-block bus.
//   ai : byte address
//   vi : write data
//   we : write enable; the write lands on the clock edge ending the cycle
// Read data (vw) travels outside the bundle, one cycle after ai.
interface mb_blk_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic           we;

  modport master (output ai, output vi, output we);
  modport slave  (input ai, input vi, input we);
endinterface

// File: rtl/creator.sv
// creator: writes a dictionary word header at `here`.
//   Layout: link lo, link hi, length byte, name bytes. This is the
//   same layout the word finder walks.
// Ports:
//   clk, rst (async, active-low)
//   mb_if        memory-block master (ai, vi, we)
//   en           level start; dropping it aborts back to IDL
//   ctx          current context (lfa of latest word)
//   here         first free byte, where the header starts
//   aw           TIB address of the counted name
//   vw           read data, valid one cycle after ai
//   bsy          header write in progress
//   err          refused because here >= 'h10000
//   ctx_o, pfa   new context and parameter field address once done
module creator
  import creator_pkg::*;
#(
  parameter int DSZ = 8,
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  mb_blk_if.master       mb_if,
  input  logic           en,
  input  logic [ASZ-1:0] ctx,
  input  logic [ASZ-1:0] here,
  input  logic [ASZ-1:0] aw,
  input  logic [DSZ-1:0] vw,
  output logic           bsy,
  output logic           err,
  output logic [ASZ-1:0] ctx_o,
  output logic [ASZ-1:0] pfa
);

  creator_sts     st_reg, st_next;
  logic [ASZ-1:0] a0_reg;      // destination pointer
  logic [ASZ-1:0] a1_reg;      // TIB pointer
  logic [8:0]     cnt_reg;     // bytes still to copy after the current one
  logic [DSZ-1:0] len_reg;
  logic           first_reg;   // next WR copies the length byte
  logic           bsy_reg;
  logic           err_reg;
  logic [ASZ-1:0] ctx_o_reg;
  logic [ASZ-1:0] pfa_reg;

  logic [DSZ-1:0] len_cur;
  logic           wr_last;

  // Only the low 16 bits of ctx form the link field.
  logic unused_ctx_hi;
  assign unused_ctx_hi = ^ctx[ASZ-1:16];

  // During the first WR the length byte is still on vw and not yet latched.
  assign len_cur = first_reg ? vw : len_reg;
  assign wr_last = first_reg ? (vw == '0) : (cnt_reg == 9'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_reg <= IDL;
    else      st_reg <= st_next;
  end

  // Next state
  always_comb begin
    st_next = st_reg;
    if (!en) begin
      st_next = IDL;
    end else begin
      case (st_reg)
        IDL:     st_next = here[16] ? DON : LK0;
        LK0:     st_next = LK1;
        LK1:     st_next = RD;
        RD:      st_next = WR;
        WR:      st_next = wr_last ? DON : RD;
        DON:     st_next = DON;
        default: st_next = IDL;
      endcase
    end
  end

  // Memory drive
  always_comb begin
    mb_if.ai = aw;
    mb_if.vi = '0;
    mb_if.we = 1'b0;
    case (st_reg)
      LK0: begin
        mb_if.ai = here;
        mb_if.vi = DSZ'(ctx[7:0]);
        mb_if.we = 1'b1;
      end
      LK1: begin
        mb_if.ai = here + ASZ'(1);
        mb_if.vi = DSZ'(ctx[15:8]);
        mb_if.we = 1'b1;
      end
      RD: mb_if.ai = a1_reg;
      WR: begin
        mb_if.ai = a0_reg;
        mb_if.vi = vw;
        mb_if.we = 1'b1;
      end
      default: ;
    endcase
  end

  // Register step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_reg    <= '0;
      a1_reg    <= '0;
      cnt_reg   <= '0;
      len_reg   <= '0;
      first_reg <= 1'b0;
      bsy_reg   <= 1'b0;
      err_reg   <= 1'b0;
      ctx_o_reg <= '0;
      pfa_reg   <= '0;
    end else if (!en) begin
      // Abort or idle: results and err are left as they were.
      bsy_reg <= 1'b0;
    end else begin
      case (st_reg)
        IDL: begin
          // On error the single DON cycle still shows bsy=1.
          bsy_reg   <= 1'b1;
          err_reg   <= here[16];
          a0_reg    <= here + ASZ'(2);
          a1_reg    <= aw;
          cnt_reg   <= '0;
          first_reg <= 1'b1;
        end
        WR: begin
          a0_reg    <= a0_reg + ASZ'(1);
          a1_reg    <= a1_reg + ASZ'(1);
          first_reg <= 1'b0;
          if (first_reg) begin
            len_reg <= vw;
            cnt_reg <= 9'(vw);
          end else begin
            cnt_reg <= cnt_reg - 9'd1;
          end
          if (wr_last) begin
            bsy_reg   <= 1'b0;
            ctx_o_reg <= here;
            pfa_reg   <= here + ASZ'(3) + ASZ'(len_cur);
          end
        end
        DON:     bsy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bsy   = bsy_reg;
  assign err   = err_reg;
  assign ctx_o = ctx_o_reg;
  assign pfa   = pfa_reg;

endmodule

// File: doc/creator.md
# creator

Dictionary word header writer for the ForthSuper core. Given the current dictionary context, the next free address (here) and a counted name string in the TIB, it writes a new word header into the memory block: a 16-bit link field (low byte first), the length byte, and the name bytes. It then returns the new context and the parameter field address. The header layout is exactly the one the dictionary word finder walks, so a `creator` write followed by a finder search for the same name must hit.

## Interface
- DSZ, 8: memory data width (byte path).
- ASZ, 17: memory address width (128K).

- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- mb_if  interface  -  generic memory-block master; drives ai (ASZ), vi (DSZ), we (1).
- en  input  1  level start/enable; low synchronously aborts and returns to IDL.
- ctx  input  ASZ  current context (lfa of latest word); 'h0ffff marks an empty dictionary.
- here  input  ASZ  first free byte; the new header starts here.
- aw  input  ASZ  TIB address of the counted name (length byte, then chars).
- vw  input  DSZ  value read from the memory block.
- bsy  output  1  1 while a header write is in progress.
- err  output  1  1 means the header was refused because here ≥ 'h10000.
- ctx_o  output  ASZ  new context (= here) once done.
- pfa  output  ASZ  here + 3 + len once done.

## Operation
- Memory read latency is one cycle: the vw for the ai presented in cycle N is valid in cycle N+1. Writes take effect on the cycle in which we=1.
- States:
  - IDL → LK0 when en is high and here[16]=0.
  - IDL → DON with err=1 when en is high and here[16]=1.
  - LK0 → LK1 → RD.
  - RD → WR.
  - WR → RD while bytes remain; otherwise WR → DON.
  - DON → IDL when en is low.
  - Any state except IDL → IDL when en is low.
- Per-state memory drive:
  - IDL, DON: ai=aw, we=0.
  - LK0: ai=here, vi=ctx[7:0], we=1.
  - LK1: ai=here+1, vi=ctx[15:8], we=1.
  - RD: ai = TIB pointer a1 (starts at aw, +1 after each WR), we=0.
  - WR: ai = destination pointer a0 (starts at here+2, +1 after each WR), vi=vw, we=1.
- Byte count:
  - The first WR copies the length byte. It also latches len=vw and loads a 9-bit remaining counter with len.
  - Each later WR decrements the counter.
  - WR → DON when the counter is 0 after the write, so exactly len+1 bytes are copied.
- Link field: ctx[15:0] is stored verbatim, including 'h0ffff. ctx[16] is ignored.
- Len is the full 8 bits, 0..255; no flag masking.
- Arithmetic: all address arithmetic is ASZ-bit and wraps modulo 2^ASZ. Pfa is computed in ASZ bits.
- Outputs in DON: bsy=0, ctx_o=here, pfa=here+3+len.
  - On error: ctx_o and pfa keep their previous values, and no write is issued.
- Abort (en low mid-op):
  - Next cycle st=IDL, we=0, bsy=0.
  - ctx_o, pfa and err keep their previous values.
  - Bytes already written stay in memory.
- Inputs ctx, here and aw are sampled continuously. The caller holds them stable while bsy=1.

## Timing
- Reset values: st=IDL, bsy=0, err=0, ctx_o=0, pfa=0, a0=0, a1=0, counter=0. Reset takes effect immediately, regardless of clk.
- Start: en is sampled high in IDL at edge t0. bsy is 1 from t0 and LK0 is active in cycle t0+1.
- Busy time: bsy stays high for 2·len+4 cycles, and clears on entry to DON. ctx_o and pfa update on the same edge that clears bsy.
- Error path: bsy=1 for exactly one cycle, then DON with err=1.
- err clears on the next start from IDL.
- Holding en high in DON does not restart. En must go low for at least one cycle before the next request.

## Structure
- In the shared ForthSuper header (next to finder_sts):
  - typedef enum logic [2:0] creator_sts {IDL, LK0, LK1, RD, WR, DON}.
  - constant NULL_LFA = 'h0ffff.
- Single module using the 4-block style: state register, next-state comb, memory-drive comb, register step. No sub-module.

## Test plan
- Empty dictionary:
  - Stimulus: ctx='h0ffff, here='h0100, TIB@'h0200 = 03 44 55 50 ("DUP").
  - Required memory: [0100..0105] = FF FF 03 44 55 50.
  - Required outputs: ctx_o='h0100, pfa='h0106, bsy high 10 cycles, err=0.
- Chaining:
  - Stimulus: ctx='h0100, here='h0106, name 01 2B ("+").
  - Required memory: [0106..0109] = 00 01 01 2B.
  - Required outputs: pfa='h010A.
  - A finder run from context 'h0106 for "+" returns hit=1 and ao0='h010A.
- Zero-length name:
  - Stimulus: TIB = 00, here='h0300.
  - Required response: exactly 3 writes, pfa='h0303, bsy high 4 cycles.
- Out of range:
  - Stimulus: here='h10000.
  - Required response: no cycle with we=1, err=1, bsy high 1 cycle, ctx_o and pfa unchanged.
- Abort:
  - Stimulus: drop en during the third WR of "DUP".
  - Required response: next cycle st=IDL and we=0, ctx_o and pfa keep their prior values. A restart then completes normally.
- Async reset:
  - Stimulus: assert rst mid-copy between clock edges.
  - Required response: bsy, err, ctx_o, pfa and we go to 0 immediately, st=IDL.
